row_scanner: RTL and testbench

ROW_SCANNER -- requirements
Module: row_scanner

---
 rtl/row_scanner_if.sv | 28 ++
 rtl/row_scanner.sv | 123 ++++++++++++
 tb/tb_row_scanner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/row_scanner_if.sv
// Row stream handshake between row_scanner and its consumer.
// The master side drives the row together with its index and last flag.
interface row_scanner_if #(
  parameter int ROW_W = 8,
  parameter int IDX_W = 4
);
  logic [ROW_W-1:0] row_data;
  logic [IDX_W-1:0] row_idx;
  logic             row_valid;
  logic             row_ready;
  logic             row_last;

  modport master (
    output row_data,
    output row_idx,
    output row_valid,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_idx,
    input  row_valid,
    input  row_last,
    output row_ready
  );
endinterface

// File: rtl/row_scanner.sv
// Snapshots a frame of rows and streams it out one row per transfer,
// forward or reversed, with deferred loads applied between frames.
module row_scanner #(
  parameter int ROW_W = 8,
  parameter int ROWS  = 16,
  parameter int IDX_W = $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROWS*ROW_W-1:0] pixels,
  input  logic                  load,
  input  logic                  en,
  input  logic                  reverse,
  output logic                  frame_done,
  row_scanner_if.master         rs
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(ROWS - 1);

  state_t                state_q, state_d;
  logic [ROWS*ROW_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  dir_q, dir_d;
  logic                  pend_q, pend_d;
  logic                  done_q, done_d;

  logic valid;
  logic last;
  logic xfer;
  logic snap;

  assign valid = (state_q == SCAN);
  assign last  = valid &
                 (dir_q ? (idx_q == '0)
                        : (idx_q == LAST_IDX));
  assign xfer  = valid & rs.row_ready;
  // Frame boundaries are the only points where FRAME may change.
  assign snap  = (state_q == IDLE) | (xfer & last);

  assign rs.row_valid = valid;
  assign rs.row_idx   = idx_q;
  assign rs.row_last  = last;
  assign frame_done   = done_q;

  always_comb begin
    rs.row_data = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rs.row_data =
          frame_q[(ROWS-1-i)*ROW_W +: ROW_W];
      end
    end
  end

  always_comb begin
    frame_d = frame_q;
    pend_d  = pend_q;
    if (snap) begin
      if (load | pend_q) begin
        frame_d = pixels;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SCAN;
          dir_d   = reverse;
          idx_d   = reverse ? LAST_IDX : '0;
        end
      end
      SCAN: begin
        if (xfer && last) begin
          done_d = 1'b1;
          if (en) begin
            dir_d = reverse;
            idx_d = reverse ? LAST_IDX : '0;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          idx_d = dir_q ? idx_q - 1'b1
                        : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_row_scanner.sv
// Directed bench for row_scanner: forward/reverse scans, stalls,
// deferred loads, mid-frame enable drop and asynchronous reset.
module tb_row_scanner;

  localparam int ROW_W = 8;
  localparam int ROWS  = 16;
  localparam int IDX_W = 4;

  localparam logic [127:0] PIX_A =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] PIX_AA = {16{8'hAA}};

  logic         clk;
  logic         rst_n;
  logic [127:0] pixels;
  logic         load;
  logic         en;
  logic         reverse;
  logic         frame_done;

  int n_chk;
  int n_pass;

  row_scanner_if #(
    .ROW_W(ROW_W),
    .IDX_W(IDX_W)
  ) rs_if ();

  row_scanner #(
    .ROW_W(ROW_W),
    .ROWS (ROWS),
    .IDX_W(IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pixels    (pixels),
    .load      (load),
    .en        (en),
    .reverse   (reverse),
    .frame_done(frame_done),
    .rs        (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_row(
    input string tag,
    input int    idx,
    input int    dat,
    input int    lst
  );
    chk({tag, "_valid"}, 32'(rs_if.row_valid), 1);
    chk({tag, "_idx"},   32'(rs_if.row_idx), idx);
    chk({tag, "_data"},  32'(rs_if.row_data), dat);
    chk({tag, "_last"},  32'(rs_if.row_last), lst);
    chk({tag, "_done"},  32'(frame_done), 0);
  endtask

  task automatic chk_end(input string tag);
    chk({tag, "_done"},  32'(frame_done), 1);
    chk({tag, "_valid"}, 32'(rs_if.row_valid), 0);
  endtask

  initial begin
    logic [3:0] pat;
    int exp_idx;
    int xfers;
    int cyc;

    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    pixels  = PIX_A;
    load    = 1'b0;
    en      = 1'b0;
    reverse = 1'b0;
    rs_if.row_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    #1;

    chk("rst_valid", 32'(rs_if.row_valid), 0);
    chk("rst_data",  32'(rs_if.row_data), 0);
    chk("rst_idx",   32'(rs_if.row_idx), 0);
    chk("rst_last",  32'(rs_if.row_last), 0);
    chk("rst_done",  32'(frame_done), 0);

    // forward frame
    load = 1'b1;
    en   = 1'b1;
    step();
    load = 1'b0;
    en   = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      chk_row("fwd", i, i * 'h11, int'(i == 15));
      step();
    end
    chk_end("fwd_end");
    step();
    chk("fwd_pulse", 32'(frame_done), 0);
    chk("fwd_idle", 32'(rs_if.row_valid), 0);

    // reverse frame
    reverse = 1'b1;
    en      = 1'b1;
    step();
    en      = 1'b0;
    reverse = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      chk_row("rev", 15 - i, (15 - i) * 'h11,
              int'(i == 15));
      step();
    end
    chk_end("rev_end");
    step();

    // stalls with ready pattern 1,0,0,1
    pat     = 4'b1001;
    exp_idx = 0;
    xfers   = 0;
    cyc     = 0;
    en      = 1'b1;
    step();
    en      = 1'b0;
    while (xfers < ROWS && cyc < 200) begin
      chk_row("stall", exp_idx, exp_idx * 'h11,
              int'(exp_idx == 15));
      rs_if.row_ready = pat[cyc % 4];
      step();
      if (rs_if.row_ready) begin
        exp_idx++;
        xfers++;
      end
      cyc++;
    end
    rs_if.row_ready = 1'b1;
    chk("stall_xfers", xfers, ROWS);
    chk_end("stall_end");
    step();

    // deferred load, back-to-back frames
    en = 1'b1;
    step();
    for (int i = 0; i < ROWS; i++) begin
      chk_row("pend", i, i * 'h11, int'(i == 15));
      if (i == 5) begin
        pixels = PIX_AA;
        load   = 1'b1;
      end
      step();
      load = 1'b0;
    end
    chk("b2b_done",  32'(frame_done), 1);
    chk("b2b_valid", 32'(rs_if.row_valid), 1);
    chk("b2b_idx",   32'(rs_if.row_idx), 0);
    chk("b2b_data",  32'(rs_if.row_data), 'hAA);
    en = 1'b0;
    step();
    for (int i = 1; i < ROWS; i++) begin
      chk_row("aa", i, 'hAA, int'(i == 15));
      step();
    end
    chk_end("aa_end");
    step();

    // enable dropped at row 3
    pixels = PIX_A;
    load   = 1'b1;
    en     = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      chk_row("endrop", i, i * 'h11, int'(i == 15));
      if (i == 3) en = 1'b0;
      step();
    end
    chk_end("endrop_end");
    step();
    chk("endrop_idle1", 32'(rs_if.row_valid), 0);
    step();
    chk("endrop_idle2", 32'(rs_if.row_valid), 0);

    // reset mid-frame with a pending load
    en = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      chk_row("pre_rst", i, i * 'h11, 0);
      if (i == 6) load = 1'b1;
      step();
      load = 1'b0;
    end
    chk("pre_rst_idx", 32'(rs_if.row_idx), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rs_if.row_valid), 0);
    chk("arst_data",  32'(rs_if.row_data), 0);
    chk("arst_idx",   32'(rs_if.row_idx), 0);
    chk("arst_last",  32'(rs_if.row_last), 0);
    chk("arst_done",  32'(frame_done), 0);
    #2;
    rst_n = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      chk_row("post_rst", i, 0, int'(i == 15));
      step();
    end
    chk_end("post_rst_end");
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
